// File: rtl/convt_job_scheduler.sv
// convt_job_scheduler: queues layer descriptors for the transposed-convolution
// controller and launches them one at a time.
//   - Descriptor FIFO (DEPTH entries) of {wgt, ifm, ofm base, expected beats}.
//   - FSM IDLE -> LAUNCH -> RUN -> REPORT; LAUNCH drives a one-cycle start_conv
//     while cfg_* hold the active job's base addresses.
//   - RUN counts out_valid beats and run cycles and ends on a fresh end_conv
//     rising edge or on timeout. REPORT emits done_pulse, done_beats, done_err.
//   - abort flushes the queue and cancels the active job without a done report.
// Ports:
//   clk1, rst                         clock, asynchronous active-high reset
//   job_valid/job_ready/job_*         descriptor push interface
//   abort / aborted                   flush request / one-cycle acknowledge
//   start_conv, cfg_*                 launch pulse and active job configuration
//   end_conv, out_valid               controller completion level and beat strobe
//   busy, queue_cnt                   FSM not idle, descriptors waiting
//   done_pulse, done_err, done_beats  per-job completion report
module convt_job_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [ADDR_W-1:0]        job_wgt_base,
  input  logic [ADDR_W-1:0]        job_ifm_base,
  input  logic [ADDR_W-1:0]        job_ofm_base,
  input  logic [CNT_W-1:0]         job_exp_beats,
  input  logic                     abort,
  output logic                     start_conv,
  output logic [ADDR_W-1:0]        cfg_wgt_base,
  output logic [ADDR_W-1:0]        cfg_ifm_base,
  output logic [ADDR_W-1:0]        cfg_ofm_base,
  input  logic                     end_conv,
  input  logic                     out_valid,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_cnt,
  output logic                     done_pulse,
  output logic                     done_err,
  output logic [CNT_W-1:0]         done_beats,
  output logic                     aborted
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DepthCnt   = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] BeatsMax   = '1;

  typedef enum logic [1:0] {StIdle, StLaunch, StRun, StReport} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               ready_q;
  logic               push, pop;
  logic [ADDR_W-1:0]  wgt_mem [DEPTH];
  logic [ADDR_W-1:0]  ifm_mem [DEPTH];
  logic [ADDR_W-1:0]  ofm_mem [DEPTH];
  logic [CNT_W-1:0]   exp_mem [DEPTH];
  logic [ADDR_W-1:0]  cfg_wgt_q, cfg_ifm_q, cfg_ofm_q;
  logic [CNT_W-1:0]   exp_q;
  logic [CNT_W-1:0]   beats_q, beats_d, beats_next;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               tflag_q, tflag_d;
  logic [CNT_W-1:0]   done_beats_q, done_beats_d;
  logic               end_conv_q;
  logic               end_edge;
  logic               aborted_q;

  // job_ready comes from the registered count, so a full FIFO refuses a push
  // even in a cycle that also pops. Reset value 0 keeps it low during reset.
  assign push = job_valid & ready_q & ~abort;
  assign pop  = (state_q == StIdle) & (count_q != '0) & ~abort;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (abort) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (push) begin
      wgt_mem[wr_ptr_q] <= job_wgt_base;
      ifm_mem[wr_ptr_q] <= job_ifm_base;
      ofm_mem[wr_ptr_q] <= job_ofm_base;
      exp_mem[wr_ptr_q] <= job_exp_beats;
    end
  end

  assign end_edge   = end_conv & ~end_conv_q;
  assign beats_next = (out_valid && beats_q != BeatsMax) ? beats_q + CNT_W'(1) : beats_q;

  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    timer_d      = timer_q;
    tflag_d      = tflag_q;
    done_beats_d = done_beats_q;
    start_conv   = 1'b0;
    done_pulse   = 1'b0;
    done_err     = 1'b0;
    done_beats   = done_beats_q;
    case (state_q)
      StIdle: begin
        if (pop) state_d = StLaunch;
      end
      StLaunch: begin
        start_conv = 1'b1;
        beats_d    = '0;
        timer_d    = '0;
        tflag_d    = 1'b0;
        state_d    = StRun;
      end
      StRun: begin
        beats_d = beats_next;
        // timer_d is the number of RUN cycles including this one, so RUN
        // lasts at most TIMEOUT cycles.
        timer_d = timer_q + CNT_W'(1);
        if (end_edge || timer_d == TimeoutCnt) begin
          tflag_d = (timer_d == TimeoutCnt);
          state_d = StReport;
        end
      end
      StReport: begin
        beats_d      = beats_next;
        done_pulse   = 1'b1;
        done_err     = tflag_q | (beats_next != exp_q);
        done_beats   = beats_next;
        done_beats_d = beats_next;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d      = StIdle;
      start_conv   = 1'b0;
      done_pulse   = 1'b0;
      done_err     = 1'b0;
      done_beats   = done_beats_q;
      done_beats_d = done_beats_q;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ready_q      <= 1'b0;
      cfg_wgt_q    <= '0;
      cfg_ifm_q    <= '0;
      cfg_ofm_q    <= '0;
      exp_q        <= '0;
      beats_q      <= '0;
      timer_q      <= '0;
      tflag_q      <= 1'b0;
      done_beats_q <= '0;
      end_conv_q   <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ready_q      <= (count_d < DepthCnt);
      beats_q      <= beats_d;
      timer_q      <= timer_d;
      tflag_q      <= tflag_d;
      done_beats_q <= done_beats_d;
      end_conv_q   <= end_conv;
      aborted_q    <= abort;
      if (pop) begin
        cfg_wgt_q <= wgt_mem[rd_ptr_q];
        cfg_ifm_q <= ifm_mem[rd_ptr_q];
        cfg_ofm_q <= ofm_mem[rd_ptr_q];
        exp_q     <= exp_mem[rd_ptr_q];
      end
    end
  end

  assign job_ready    = ready_q;
  assign queue_cnt    = count_q;
  assign busy         = (state_q != StIdle);
  assign aborted      = aborted_q;
  assign cfg_wgt_base = cfg_wgt_q;
  assign cfg_ifm_base = cfg_ifm_q;
  assign cfg_ofm_base = cfg_ofm_q;

endmodule
